guess_grader: RTL and testbench
===============================

GUESS_GRADER -- requirements
Module: guess_grader

Interface
REQ-001 The block SHALL have the following ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- GradeIt  input  1  grade request, level from debounced key; rising edge triggers one grade.
- clearGame  input  1  synchronous clear of results and abort of any grade in progress.
- Guess  input  12  four 3-bit shapes; position i occupies bits [3i+2:3i], i=0..3.
- masterPattern  input  12  secret pattern, same packing as Guess.
- Znarly  output  4  count of positions with exact shape match (0..4).
- Zood  output  4  count of right-shape/wrong-position matches (0..4).
- GameWon  output  1  high while the last completed grade had Znarly==4.
- gradeDone  output  1  one-cycle pulse when new results are valid.
- busy  output  1  high while a grade is in progress.

Function
REQ-002 The FSM SHALL have states IDLE, EXACT, SCAN and DONE.
REQ-003 The block SHALL register GradeIt each cycle and detect a rising edge (current 1, previous 0).
REQ-004 In IDLE, a rising edge SHALL capture Guess and masterPattern into internal registers and move to EXACT on the same edge.
REQ-005 EXACT (one cycle) SHALL compute a 4-bit exact-match mask, load the exact count, and mark those guess and master positions used, then move to SCAN.
REQ-006 SCAN SHALL last exactly 4 cycles with position index j=0..3, one guess position per cycle:
- If guess[j] is unused, find the lowest-index unused master position with an equal shape.
- On a hit, mark that master position used and increment the Zood accumulator.
REQ-007 After j=3 the FSM SHALL enter DONE for one cycle, then return to IDLE.
REQ-008 In DONE, gradeDone SHALL be 1, and Znarly, Zood and GameWon SHALL update on the edge entering DONE.
REQ-009 Latency SHALL be fixed: request edge at cycle k, EXACT at k+1, SCAN at k+2..k+5, DONE at k+6.
REQ-010 Znarly, Zood and GameWon SHALL hold their values until the next DONE, clearGame, or reset.
REQ-011 busy SHALL be 1 in EXACT, SCAN and DONE, and 0 in IDLE.
REQ-012 GradeIt edges arriving while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-013 A GradeIt held high SHALL produce exactly one grade.
REQ-014 Changes to Guess or masterPattern after capture SHALL NOT affect the grade in progress.
REQ-015 clearGame SHALL take priority over everything except reset:
- Next state is IDLE.
- Znarly, Zood and GameWon become 0; gradeDone is 0.
- A simultaneous GradeIt edge is ignored.
REQ-016 Znarly+Zood SHALL never exceed 4.
REQ-017 Accumulators SHALL be 4 bits wide with no wrap-around.
REQ-018 All 3-bit shape codes, including 0, SHALL be treated as valid and compared by equality.

Reset
REQ-019 While reset is high, the block SHALL hold:
- FSM in IDLE.
- Znarly=0, Zood=0, GameWon=0, gradeDone=0, busy=0.
- All internal used-masks, accumulators and the GradeIt history register cleared.
REQ-020 Reset asserted mid-grade SHALL abort the grade with no gradeDone pulse.
REQ-021 After reset, a GradeIt held high since before reset release SHALL NOT trigger a grade.

Structure
REQ-022 A shared package SHALL define:
- The state enum.
- SHAPE_W=3 and NUM_POS=4.
- GUESS_W=SHAPE_W*NUM_POS.
REQ-023 Exact-mask generation SHALL be a combinational sub-module named exact_match_finder (mask plus popcount).

Verification
REQ-024 The bench SHALL cover the following directed scenarios (shapes listed as positions 3..0):
- Master 1,2,3,4, guess 1,2,3,4, GradeIt edge -> gradeDone at k+6; Znarly=4, Zood=0, GameWon=1.
- Master 1,2,3,4, guess 4,3,2,1 -> Znarly=0, Zood=4, GameWon=0.
- Master 1,2,3,4, guess 1,1,1,1 -> Znarly=1, Zood=0. Master 1,1,2,2, guess 2,2,1,1 -> Znarly=0, Zood=4.
- GradeIt held high 20 cycles, then a second edge during SCAN -> exactly one gradeDone pulse; results from the first capture only.
- clearGame at k+3 -> busy=0 next cycle, no gradeDone, outputs 0. Reset at k+4 -> same result, and outputs stay 0 after release.
- Guess changed to 0,0,0,0 at k+2 during a 1,2,3,4 vs 1,2,3,4 grade -> Znarly=4 still reported.

Source files
------------

// File: rtl/guess_grader_pkg.sv
// Shared types and sizing for the guess grader: shape packing, FSM states,
// and a helper to pull one shape out of a packed pattern.
package guess_grader_pkg;
    localparam int SHAPE_W = 3;
    localparam int NUM_POS = 4;
    localparam int GUESS_W = SHAPE_W * NUM_POS;
    localparam int CNT_W   = 4;
    localparam int PIDX_W  = $clog2(NUM_POS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXACT = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [SHAPE_W-1:0] shape_at(input logic [GUESS_W-1:0] v,
                                                    input int unsigned idx);
        return v[idx*SHAPE_W +: SHAPE_W];
    endfunction
endpackage

// File: rtl/guess_grader_exact.sv
// exact_match_finder: per-position equality mask between guess and master,
// plus the number of set mask bits.
module exact_match_finder
    import guess_grader_pkg::*;
(
    input  logic [GUESS_W-1:0] guess,
    input  logic [GUESS_W-1:0] master,
    output logic [NUM_POS-1:0] mask,
    output logic [CNT_W-1:0]   count
);
    always_comb begin
        mask  = '0;
        count = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (shape_at(guess, i) == shape_at(master, i)) begin
                mask[i] = 1'b1;
                count   = count + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/guess_grader.sv
// Grades a captured guess against a captured master pattern: one cycle for
// exact matches, four cycles scanning for shape-only matches, one DONE cycle.
module guess_grader
    import guess_grader_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               GradeIt,
    input  logic               clearGame,
    input  logic [GUESS_W-1:0] Guess,
    input  logic [GUESS_W-1:0] masterPattern,
    output logic [CNT_W-1:0]   Znarly,
    output logic [CNT_W-1:0]   Zood,
    output logic               GameWon,
    output logic               gradeDone,
    output logic               busy
);
    // Handshake: gradeDone is a one-cycle strobe; Znarly/Zood/GameWon become
    // valid with it and hold until the next strobe, clearGame or reset.
    state_t              state;
    logic                gradeit_q;
    logic                armed;
    logic [GUESS_W-1:0]  guess_q;
    logic [GUESS_W-1:0]  master_q;
    logic [NUM_POS-1:0]  guess_used;
    logic [NUM_POS-1:0]  master_used;
    logic [CNT_W-1:0]    znarly_acc;
    logic [CNT_W-1:0]    zood_acc;
    logic [PIDX_W-1:0]   scan_idx;

    logic [NUM_POS-1:0]  exact_mask;
    logic [CNT_W-1:0]    exact_count;
    logic                grade_rise;
    logic [SHAPE_W-1:0]  cur_shape;
    logic                hit;
    logic [PIDX_W-1:0]   hit_pos;
    logic [NUM_POS-1:0]  hit_mask;
    logic [CNT_W-1:0]    zood_next;

    exact_match_finder u_exact (
        .guess  (guess_q),
        .master (master_q),
        .mask   (exact_mask),
        .count  (exact_count)
    );

    // armed stays low until GradeIt is seen low, so a key held through reset
    // release does not look like a fresh press.
    assign grade_rise = GradeIt & ~gradeit_q & armed;

    always_comb begin
        cur_shape = shape_at(guess_q, 32'(scan_idx));
        hit       = 1'b0;
        hit_pos   = '0;
        if (!guess_used[scan_idx]) begin
            for (int k = NUM_POS - 1; k >= 0; k--) begin
                if (!master_used[k] && shape_at(master_q, k) == cur_shape) begin
                    hit     = 1'b1;
                    hit_pos = PIDX_W'(k);
                end
            end
        end
        hit_mask  = hit ? (NUM_POS'(1) << hit_pos) : '0;
        zood_next = zood_acc + (hit ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gradeit_q   <= 1'b0;
            armed       <= 1'b0;
            guess_q     <= '0;
            master_q    <= '0;
            guess_used  <= '0;
            master_used <= '0;
            znarly_acc  <= '0;
            zood_acc    <= '0;
            scan_idx    <= '0;
            Znarly      <= '0;
            Zood        <= '0;
            GameWon     <= 1'b0;
            gradeDone   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            gradeit_q <= GradeIt;
            if (!GradeIt) begin
                armed <= 1'b1;
            end
            gradeDone <= 1'b0;
            if (clearGame) begin
                state       <= IDLE;
                busy        <= 1'b0;
                Znarly      <= '0;
                Zood        <= '0;
                GameWon     <= 1'b0;
                guess_used  <= '0;
                master_used <= '0;
                znarly_acc  <= '0;
                zood_acc    <= '0;
                scan_idx    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (grade_rise) begin
                            guess_q  <= Guess;
                            master_q <= masterPattern;
                            state    <= EXACT;
                            busy     <= 1'b1;
                        end
                    end
                    EXACT: begin
                        guess_used  <= exact_mask;
                        master_used <= exact_mask;
                        znarly_acc  <= exact_count;
                        zood_acc    <= '0;
                        scan_idx    <= '0;
                        state       <= SCAN;
                    end
                    SCAN: begin
                        master_used <= master_used | hit_mask;
                        zood_acc    <= zood_next;
                        scan_idx    <= scan_idx + PIDX_W'(1);
                        if (scan_idx == PIDX_W'(NUM_POS - 1)) begin
                            state     <= DONE;
                            Znarly    <= znarly_acc;
                            Zood      <= zood_next;
                            GameWon   <= (znarly_acc == CNT_W'(NUM_POS));
                            gradeDone <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_guess_grader.sv
// Directed bench for guess_grader: drivers push expected results, a monitor
// pops and compares them whenever gradeDone pulses.
module tb_guess_grader;
    logic        clock = 1'b0;
    logic        reset;
    logic        GradeIt;
    logic        clearGame;
    logic [11:0] Guess;
    logic [11:0] masterPattern;
    logic [3:0]  Znarly;
    logic [3:0]  Zood;
    logic        GameWon;
    logic        gradeDone;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_count  = 0;

    logic [8:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [8:0] mon_exp;
    int         mon_cyc;

    guess_grader dut (
        .clock         (clock),
        .reset         (reset),
        .GradeIt       (GradeIt),
        .clearGame     (clearGame),
        .Guess         (Guess),
        .masterPattern (masterPattern),
        .Znarly        (Znarly),
        .Zood          (Zood),
        .GameWon       (GameWon),
        .gradeDone     (gradeDone),
        .busy          (busy)
    );

    // clock / cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [11:0] pat(input int p3, input int p2, input int p1, input int p0);
        return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    function automatic logic [8:0] res(input int zn, input int zo, input int won);
        return {4'(zn), 4'(zo), 1'(won)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (gradeDone) begin
            done_count++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: Znarly=%0d Zood=%0d GameWon=%0d at cycle %0d, none expected",
                         Znarly, Zood, GameWon, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                if ({Znarly, Zood, GameWon} !== mon_exp || cyc != mon_cyc) begin
                    miscompares++;
                    $display("FAIL grade_result: got Zn=%0d Zo=%0d W=%0d at cycle %0d, expected Zn=%0d Zo=%0d W=%0d at cycle %0d",
                             Znarly, Zood, GameWon, cyc,
                             mon_exp[8:5], mon_exp[4:1], mon_exp[0], mon_cyc);
                end
            end
        end
    end

    // driver: request edge driven at negedge cycle k, result expected at k+6
    task automatic issue(input logic [11:0] m, input logic [11:0] g, input logic [8:0] e);
        @(negedge clock);
        masterPattern = m;
        Guess         = g;
        GradeIt       = 1'b1;
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 6);
    endtask

    task automatic wait_done(input int start_count, input string name);
        int n;
        n = 0;
        while (done_count == start_count && n < 30) begin
            @(posedge clock);
            n++;
        end
        check({name, "_timeout"}, int'(done_count > start_count), 1);
    endtask

    task automatic grade(input logic [11:0] m, input logic [11:0] g, input logic [8:0] e,
                         input string name);
        int s;
        s = done_count;
        issue(m, g, e);
        @(negedge clock);
        GradeIt = 1'b0;
        wait_done(s, name);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_znarly"}, int'(Znarly), 0);
        check({name, "_zood"}, int'(Zood), 0);
        check({name, "_won"}, int'(GameWon), 0);
        check({name, "_done"}, int'(gradeDone), 0);
    endtask

    initial begin
        int s;
        reset         = 1'b1;
        GradeIt       = 1'b0;
        clearGame     = 1'b0;
        Guess         = '0;
        masterPattern = '0;
        repeat (2) @(negedge clock);
        check_cleared("reset_state");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        grade(pat(1,2,3,4), pat(1,2,3,4), res(4,0,1), "all_exact");
        grade(pat(1,2,3,4), pat(4,3,2,1), res(0,4,0), "all_swapped");
        grade(pat(1,2,3,4), pat(1,1,1,1), res(1,0,0), "one_exact_dups");
        grade(pat(1,1,2,2), pat(2,2,1,1), res(0,4,0), "pair_swap");
        grade(pat(0,0,5,7), pat(0,7,0,5), res(1,3,0), "shape_zero");

        // held high 20 cycles with a re-press during SCAN; guess changes after capture
        s = done_count;
        issue(pat(1,2,3,4), pat(1,2,4,3), res(2,2,0));
        @(negedge clock);
        Guess = pat(4,4,4,4);
        check("busy_in_exact", int'(busy), 1);
        @(negedge clock);
        GradeIt = 1'b0;
        @(negedge clock);
        GradeIt = 1'b1;
        repeat (17) @(negedge clock);
        GradeIt = 1'b0;
        repeat (3) @(negedge clock);
        check("held_one_grade", done_count - s, 1);

        // clearGame mid-scan
        s = done_count;
        @(negedge clock);
        masterPattern = pat(1,2,3,4);
        Guess         = pat(1,2,3,4);
        GradeIt       = 1'b1;
        @(negedge clock);
        GradeIt = 1'b0;
        @(negedge clock);
        @(negedge clock);
        clearGame = 1'b1;
        @(negedge clock);
        clearGame = 1'b0;
        check_cleared("clear_mid_scan");
        repeat (8) @(negedge clock);
        check("clear_no_done", done_count - s, 0);

        // clearGame together with a GradeIt edge
        @(negedge clock);
        GradeIt   = 1'b1;
        clearGame = 1'b1;
        @(negedge clock);
        clearGame = 1'b0;
        check("clear_beats_edge_busy", int'(busy), 0);
        repeat (8) @(negedge clock);
        GradeIt = 1'b0;
        check("clear_beats_edge_no_done", done_count - s, 0);

        // reset mid-grade with GradeIt held through release
        grade(pat(1,2,3,4), pat(1,2,3,4), res(4,0,1), "before_reset");
        s = done_count;
        @(negedge clock);
        GradeIt = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_cleared("reset_mid_grade");
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check_cleared("after_reset_release");
        check("reset_no_done", done_count - s, 0);
        GradeIt = 1'b0;
        repeat (2) @(negedge clock);

        // guess changed after capture must not matter
        s = done_count;
        issue(pat(1,2,3,4), pat(1,2,3,4), res(4,0,1));
        @(negedge clock);
        GradeIt = 1'b0;
        @(negedge clock);
        Guess = pat(0,0,0,0);
        wait_done(s, "guess_change");

        repeat (5) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
